// File: rtl/iddr_deser4_if.sv
// iddr_deser4 pin-side bundle.
// Serial data in, capture pair and packed word out.
interface iddr_deser4_if;

   logic       D;
   logic       BITSLIP;
   logic       Q1;
   logic       Q2;
   logic [3:0] WORD;
   logic       WORD_VLD;

   modport master (
      output D,
      output BITSLIP,
      input  Q1,
      input  Q2,
      input  WORD,
      input  WORD_VLD
   );

   modport slave (
      input  D,
      input  BITSLIP,
      output Q1,
      output Q2,
      output WORD,
      output WORD_VLD
   );

endinterface

// File: rtl/iddr_deser4.sv
// iddr_deser4: DDR input capture cell with 1:4 gearbox.
// BITSLIP moves the word boundary one bit per accepted pulse.
module iddr_deser4 #(
   parameter string DDR_CLK_MODE  = "OPPOSITE_EDGE",
   parameter logic  IS_C_INVERTED = 1'b0,
   parameter logic  IS_D_INVERTED = 1'b0,
   parameter logic  SRVAL         = 1'b0
) (
   input logic          C,
   input logic          SR,
   iddr_deser4_if.slave io
);

   localparam bit MODE_OPP  =
      (DDR_CLK_MODE == "OPPOSITE_EDGE");
   localparam bit MODE_PIPE =
      (DDR_CLK_MODE == "SAME_EDGE_PIPELINED");

   logic       w_clk;
   logic       d_in;

   logic       rr;
   logic       rf;
   logic       q1_r;
   logic       q2_r;

   logic [2:0] hist;
   logic       phase;
   logic       off;
   logic [1:0] hold;
   logic [3:0] word_r;
   logic       vld_r;

   logic [1:0] pair;
   logic [4:0] hist_nxt;
   logic [3:0] word_sel;
   logic       slip_ok;
   logic       slip_wrap;
   logic [1:0] hold_nxt;

   assign w_clk = C ^ IS_C_INVERTED;
   assign d_in  = io.D ^ IS_D_INVERTED;

   // fall-domain sample: D on the falling edge
   always_ff @(negedge w_clk) begin
      if (SR) begin
         rf <= SRVAL;
      end else begin
         rf <= d_in;
      end
   end

   // rise-domain capture and Q1/Q2 presentation
   always_ff @(posedge w_clk) begin
      if (SR) begin
         rr   <= SRVAL;
         q1_r <= SRVAL;
         q2_r <= SRVAL;
      end else begin
         rr   <= d_in;
         q1_r <= MODE_PIPE ? rr : d_in;
         q2_r <= rf;
      end
   end

   // gearbox pair is always the aligned previous rise/fall pair
   always_comb begin
      pair      = {rr, rf};
      hist_nxt  = {hist, pair};
      word_sel  = off ? hist_nxt[4:1]
                      : hist_nxt[3:0];
      slip_ok   = io.BITSLIP && (hold == 2'd0);
      slip_wrap = slip_ok && off;
      hold_nxt  = 2'd0;
      if (slip_ok) begin
         hold_nxt = 2'd2;
      end else if (hold != 2'd0) begin
         hold_nxt = hold - 2'd1;
      end
   end

   // bit history and emit phase; a wrap slip holds phase
   always_ff @(posedge w_clk) begin
      if (SR) begin
         hist  <= 3'd0;
         phase <= 1'b0;
      end else begin
         hist <= hist_nxt[2:0];
         if (!slip_wrap) begin
            phase <= ~phase;
         end
      end
   end

   // word output uses the offset in force before any slip
   always_ff @(posedge w_clk) begin
      if (SR) begin
         word_r <= 4'd0;
         vld_r  <= 1'b0;
      end else if (phase) begin
         word_r <= word_sel;
         vld_r  <= 1'b1;
      end else begin
         vld_r  <= 1'b0;
      end
   end

   // bitslip acceptance with a two-rise lockout
   always_ff @(posedge w_clk) begin
      if (SR) begin
         off  <= 1'b0;
         hold <= 2'd0;
      end else begin
         hold <= hold_nxt;
         if (slip_ok) begin
            off <= ~off;
         end
      end
   end

   assign io.Q1       = q1_r;
   assign io.Q2       = MODE_OPP ? rf : q2_r;
   assign io.WORD     = word_r;
   assign io.WORD_VLD = vld_r;

endmodule
